// File: rtl/memory_arbiter.sv
// memory_arbiter: shares the single data memory port between the instruction
// fetch stage and the load/store stage. One access per arbitration slot, the
// memory port is driven for one cycle from latched operands, and the owner
// gets a one-cycle response pulse. Data accesses win unless a fetch has lost
// STARVE_LIMIT consecutive slots.

// Protocol checker: watches grants, strobes and response pulses for
// combinations the arbiter must never produce.
module memory_arbiter_checker (
  input logic i_Clock,
  input logic i_Reset,
  input logic i_IGrant,
  input logic i_DGrant,
  input logic i_InAccess,
  input logic i_ReadEn,
  input logic i_WriteEn,
  input logic i_IValid,
  input logic i_DValid
);

  // Sample the invariants on every active clock edge outside reset.
  always @(posedge i_Clock) begin
    if (!i_Reset) begin
      assert (!(i_IGrant && i_DGrant))
        else $error("memory_arbiter: fetch and data granted together");
      assert (!(i_InAccess && (i_IGrant || i_DGrant)))
        else $error("memory_arbiter: grant issued during ACCESS");
      assert (!(i_ReadEn && i_WriteEn))
        else $error("memory_arbiter: read and write strobes together");
      assert (!(i_IValid && i_DValid))
        else $error("memory_arbiter: two response pulses together");
    end
  end

endmodule

module memory_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        i_Clock,
  input  logic        i_Reset,

  input  logic        i_IReq,
  input  logic [31:0] i_IAddress,
  output logic        o_IGrant,
  output logic        o_IValid,
  output logic [31:0] o_IData,
  output logic        o_IFault,

  input  logic        i_DReq,
  input  logic        i_DWrite,
  input  logic [31:0] i_DAddress,
  input  logic [31:0] i_DDataIn,
  input  logic [2:0]  i_DMode,
  output logic        o_DGrant,
  output logic        o_DValid,
  output logic [31:0] o_DData,
  output logic        o_DFault,

  output logic        o_MemReadEnable,
  output logic        o_MemWriteEnable,
  output logic [31:0] o_MemAddress,
  output logic [31:0] o_MemDataIn,
  output logic [2:0]  o_MemMode,
  input  logic [31:0] i_MemDataOut,
  input  logic        i_MemMisalignedAccess,
  input  logic        i_MemBadInstruction
);

  localparam logic [2:0] LOAD_WORD  = 3'b010;
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  state_e      state_q;
  logic [3:0]  starve_q;
  logic [3:0]  starve_d;
  logic        owner_i_q;     // 1: the in-flight access belongs to fetch
  logic        write_q;       // in-flight access is a store
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  mode_q;
  logic        rd_en_q;
  logic        wr_en_q;
  logic        i_valid_q;
  logic        i_fault_q;
  logic [31:0] i_data_q;
  logic        d_valid_q;
  logic        d_fault_q;
  logic [31:0] d_data_q;

  logic        arb_slot_s;
  logic        starve_hit_s;
  logic        i_grant_s;
  logic        d_grant_s;
  logic        mem_fault_s;
  logic [31:0] resp_data_s;
  logic        in_access_s;

  // Response word seen by the requester: faults and stores return zero.
  function automatic logic [31:0] resp_word(
    input logic [31:0] data,
    input logic        fault,
    input logic        is_store
  );
    logic [31:0] word;
    if (fault || is_store) begin
      word = 32'h0000_0000;
    end else begin
      word = data;
    end
    return word;
  endfunction

  // Arbitration: slots exist in IDLE and RESP; data wins unless fetch is starved.
  always_comb begin
    arb_slot_s   = 1'b0;
    starve_hit_s = 1'b0;
    i_grant_s    = 1'b0;
    d_grant_s    = 1'b0;
    if (!i_Reset && ((state_q == ST_IDLE) || (state_q == ST_RESP))) begin
      arb_slot_s = 1'b1;
    end else begin
      arb_slot_s = 1'b0;
    end
    starve_hit_s = (starve_q == STARVE_MAX);
    i_grant_s    = arb_slot_s & i_IReq & (~i_DReq | starve_hit_s);
    d_grant_s    = arb_slot_s & i_DReq & ~i_grant_s;
  end

  // Starvation counter: counts slots a requesting fetch loses, saturating.
  always_comb begin
    starve_d = starve_q;
    if (arb_slot_s) begin
      if (!i_IReq || i_grant_s) begin
        starve_d = 4'd0;
      end else if (starve_q < STARVE_MAX) begin
        starve_d = starve_q + 4'd1;
      end else begin
        starve_d = starve_q;
      end
    end else begin
      starve_d = starve_q;
    end
  end

  // Memory result qualification for the access being completed.
  always_comb begin
    mem_fault_s = i_MemMisalignedAccess | i_MemBadInstruction;
    resp_data_s = resp_word(i_MemDataOut, mem_fault_s, write_q & ~owner_i_q);
    in_access_s = (state_q == ST_ACCESS);
  end

  // Main FSM: latches the winner's operands, drives one memory cycle and
  // returns the captured result as a one-cycle pulse.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q   <= ST_IDLE;
      starve_q  <= 4'd0;
      owner_i_q <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= 32'h0000_0000;
      wdata_q   <= 32'h0000_0000;
      mode_q    <= 3'b000;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      i_valid_q <= 1'b0;
      i_fault_q <= 1'b0;
      i_data_q  <= 32'h0000_0000;
      d_valid_q <= 1'b0;
      d_fault_q <= 1'b0;
      d_data_q  <= 32'h0000_0000;
    end else begin
      starve_q  <= starve_d;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      i_valid_q <= 1'b0;
      i_fault_q <= 1'b0;
      d_valid_q <= 1'b0;
      d_fault_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_RESP: begin
          if (i_grant_s) begin
            state_q   <= ST_ACCESS;
            owner_i_q <= 1'b1;
            write_q   <= 1'b0;
            addr_q    <= i_IAddress;
            mode_q    <= LOAD_WORD;
            rd_en_q   <= 1'b1;
          end else if (d_grant_s) begin
            state_q   <= ST_ACCESS;
            owner_i_q <= 1'b0;
            write_q   <= i_DWrite;
            addr_q    <= i_DAddress;
            wdata_q   <= i_DDataIn;
            mode_q    <= i_DMode;
            rd_en_q   <= ~i_DWrite;
            wr_en_q   <= i_DWrite;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          state_q <= ST_RESP;
          if (owner_i_q) begin
            i_valid_q <= 1'b1;
            i_fault_q <= mem_fault_s;
            i_data_q  <= resp_data_s;
          end else begin
            d_valid_q <= 1'b1;
            d_fault_q <= mem_fault_s;
            d_data_q  <= resp_data_s;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_IGrant         = i_grant_s;
  assign o_DGrant         = d_grant_s;
  assign o_IValid         = i_valid_q;
  assign o_IData          = i_data_q;
  assign o_IFault         = i_fault_q;
  assign o_DValid         = d_valid_q;
  assign o_DData          = d_data_q;
  assign o_DFault         = d_fault_q;
  assign o_MemReadEnable  = rd_en_q;
  assign o_MemWriteEnable = wr_en_q;
  assign o_MemAddress     = addr_q;
  assign o_MemDataIn      = wdata_q;
  assign o_MemMode        = mode_q;

  memory_arbiter_checker u_checker (
    .i_Clock    (i_Clock),
    .i_Reset    (i_Reset),
    .i_IGrant   (i_grant_s),
    .i_DGrant   (d_grant_s),
    .i_InAccess (in_access_s),
    .i_ReadEn   (rd_en_q),
    .i_WriteEn  (wr_en_q),
    .i_IValid   (i_valid_q),
    .i_DValid   (d_valid_q)
  );

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-port arbiter that shares the single data memory between the instruction-fetch stage and the load/store stage ahead of the move to a unified memory. It accepts one request per arbitration slot, drives the memory port for one cycle from registered operands, captures read data and fault flags, and returns a one-cycle response pulse to the winning requester. Data accesses have priority; a starvation counter bounds fetch latency.

## Interface

Parameters:
- STARVE_LIMIT, 4: consecutive lost arbitrations after which a pending fetch beats a pending data access (1..15).

Ports:
- i_Clock  in  1  clock; all state on rising edge
- i_Reset  in  1  asynchronous, active-high reset
- i_IReq  in  1  fetch request; held with i_IAddress stable until o_IGrant
- i_IAddress  in  32  fetch byte address (always LOAD_WORD)
- o_IGrant  out  1  combinational; fetch request accepted this cycle
- o_IValid  out  1  one-cycle fetch response pulse
- o_IData  out  32  fetched word; holds until next fetch response
- o_IFault  out  1  with o_IValid: misaligned or bad-mode fetch
- i_DReq  in  1  data request; operands held stable until o_DGrant
- i_DWrite  in  1  1 = store, 0 = load
- i_DAddress  in  32  data byte address
- i_DDataIn  in  32  store data
- i_DMode  in  3  funct3 load/store mode (LOAD_*/STORE_* codes)
- o_DGrant  out  1  combinational; data request accepted this cycle
- o_DValid  out  1  one-cycle data response pulse (loads and stores)
- o_DData  out  32  load result (0 for stores and faults); holds until next data response
- o_DFault  out  1  with o_DValid: misaligned access or bad mode
- o_MemReadEnable, o_MemWriteEnable  out  1 each  memory strobes, asserted only in ACCESS
- o_MemAddress  out  32, o_MemDataIn  out  32, o_MemMode  out  3  latched operands
- i_MemDataOut  in  32, i_MemMisalignedAccess  in  1, i_MemBadInstruction  in  1  memory results, sampled at end of ACCESS

## Operation

- States: IDLE, ACCESS, RESP. Reset -> IDLE.
- IDLE: if any request, grant one, latch its operands and owner, -> ACCESS; else stay.
- ACCESS: drive memory from latched operands (fetch: read, mode LOAD_WORD); at clock edge capture i_MemDataOut and fault = i_MemMisalignedAccess | i_MemBadInstruction; -> RESP.
- RESP: pulse owner's o_xValid with captured data/fault; in the same cycle arbitrate again: grant -> ACCESS, none -> IDLE.
- Grants occur only in IDLE and RESP; at most one grant per cycle; never both.
- Priority: if both request, D wins unless starve counter == STARVE_LIMIT, then I wins.
- Starve counter (4-bit): increments when I requests in an arbitration slot and D is granted; clears when I is granted or i_IReq is low in a slot; saturates at STARVE_LIMIT.
- Faulted load: o_DData = 0, o_DFault = 1. Faulted store: memory suppresses the byte enables itself; arbiter reports o_DFault = 1. Faulted fetch: o_IData = 0, o_IFault = 1.
- Outside ACCESS: both strobes 0; address/data/mode outputs hold last latched values.
- Reset (any state, including mid-ACCESS): state IDLE, counter 0, all outputs 0; in-flight access dropped, no response pulse; requester reissues.

## Timing

- Grant cycle T (combinational from i_xReq) -> ACCESS at T+1 -> o_xValid at T+2.
- Back-to-back: next grant possible at T+2 (in RESP); peak throughput one access per 2 cycles.
- Requester may change operands or drop request in cycle after grant.
- Worst-case fetch wait with continuous D traffic: STARVE_LIMIT lost slots, granted on the next.
- Reset values: o_IGrant, o_DGrant, o_IValid, o_DValid, o_IFault, o_DFault, strobes 0; o_IData, o_DData, o_MemAddress, o_MemDataIn, o_MemMode all 0.

## Test plan

- Reset: assert i_Reset with requests high -> all outputs 0, no grant until deassert; first grant the cycle after.
- Single fetch 0x100, memory word 0xDEADBEEF: o_IGrant at T, o_MemReadEnable at T+1 address 0x100 mode LOAD_WORD, o_IValid at T+2 with o_IData 0xDEADBEEF, o_IFault 0.
- Simultaneous I (0x0) and D load-byte 0x203 (byte 0x80): D granted T, o_DData 0xFFFFFF80 at T+2; I granted at T+2, o_IValid at T+4.
- Starvation, STARVE_LIMIT=4: D and I requesting continuously -> D wins 4 slots, I granted in slot 5, counter clears, D wins slot 6.
- Store half to 0x201: o_MemWriteEnable pulses, memory unchanged, o_DValid with o_DFault 1, o_DData 0.
- Reset asserted during ACCESS of a load: no o_DValid ever for it; after release, reissued request granted and completes normally.
